phase_sequencer: RTL and testbench

- Run/stop controller and five-phase instruction sequencer for the SIMPLE processor core.
- Converts the raw exec button into a run state and generates the one-hot phase strobes p1..p5 (fetch, reg-read, execute, memory, writeback).
- Decodes the latched IR together with the SZCV flags into per-phase control strobes.
- Sits directly upstream of the datapath: the datapath's IR/AR/BR/DR/MDR/RF/PC clock enables come from this block.

---
 rtl/simple_pkg.sv | 143 ++++++++++++++
 rtl/phase_sequencer_if.sv | 36 +++
 rtl/exec_sync.sv | 25 ++
 rtl/phase_sequencer.sv | 121 ++++++++++++
 tb/tb_phase_sequencer.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/simple_pkg.sv
// Shared opcode fields, sequencer state encoding and instruction decode for
// the SIMPLE core phase sequencer.
package simple_pkg;

    localparam int PHASES = 5;

    localparam int PH_FETCH = 0;
    localparam int PH_REG   = 1;
    localparam int PH_EXEC  = 2;
    localparam int PH_MEM   = 3;
    localparam int PH_WB    = 4;

    localparam logic [PHASES-1:0] PH_FIRST = 5'b00001;

    localparam logic [1:0] MAJ_LD  = 2'b00;
    localparam logic [1:0] MAJ_ST  = 2'b01;
    localparam logic [1:0] MAJ_BR  = 2'b10;
    localparam logic [1:0] MAJ_ALU = 2'b11;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_CMP = 4'b0101;
    localparam logic [3:0] OP_MOV = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SLR = 4'b1001;
    localparam logic [3:0] OP_SRL = 4'b1010;
    localparam logic [3:0] OP_SRA = 4'b1011;
    localparam logic [3:0] OP_IN  = 4'b1100;
    localparam logic [3:0] OP_OUT = 4'b1101;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [2:0] BR_LI   = 3'b000;
    localparam logic [2:0] BR_B    = 3'b100;
    localparam logic [2:0] BR_COND = 3'b111;

    localparam logic [2:0] CC_BE  = 3'b000;
    localparam logic [2:0] CC_BLT = 3'b001;
    localparam logic [2:0] CC_BLE = 3'b010;
    localparam logic [2:0] CC_BNE = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_RUN       = 2'b01,
        ST_STOP_PEND = 2'b10,
        ST_HALT      = 2'b11
    } seq_state_e;

    typedef struct packed {
        logic flag_we;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic out_en;
        logic mem_to_reg;
        logic alu_src_imm;
        logic branch;
        logic halt;
    } ctrl_t;

    typedef struct packed {
        logic ir_load;
        logic ab_load;
        logic dr_load;
        logic flag_we;
        logic mem_read;
        logic mem_write;
        logic out_en;
        logic reg_write;
        logic mem_to_reg;
        logic alu_src_imm;
        logic pc_load_branch;
        logic pc_inc;
    } strobe_t;

    function automatic logic [PHASES-1:0] rotate_phase(input logic [PHASES-1:0] p);
        return {p[PHASES-2:0], p[PHASES-1]};
    endfunction

    // branch is the resolved (taken) branch, not merely "is a branch"
    function automatic ctrl_t decode(input logic [15:0] ir, input logic [3:0] szcv);
        ctrl_t c;
        logic  s, z, v;
        c = '0;
        s = szcv[3];
        z = szcv[2];
        v = szcv[0];
        case (ir[15:14])
            MAJ_ALU: begin
                case (ir[7:4])
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
                    OP_SLL, OP_SLR, OP_SRL, OP_SRA: begin
                        c.flag_we   = 1'b1;
                        c.reg_write = 1'b1;
                    end
                    OP_CMP: c.flag_we = 1'b1;
                    OP_MOV: c.reg_write = 1'b1;
                    OP_IN: begin
                        c.mem_read   = 1'b1;
                        c.mem_to_reg = 1'b1;
                        c.reg_write  = 1'b1;
                    end
                    OP_OUT:  c.out_en = 1'b1;
                    OP_HLT:  c.halt = 1'b1;
                    default: ;
                endcase
            end
            MAJ_LD: begin
                c.alu_src_imm = 1'b1;
                c.mem_read    = 1'b1;
                c.mem_to_reg  = 1'b1;
                c.reg_write   = 1'b1;
            end
            MAJ_ST: begin
                c.alu_src_imm = 1'b1;
                c.mem_write   = 1'b1;
            end
            default: begin
                case (ir[13:11])
                    BR_LI: begin
                        c.alu_src_imm = 1'b1;
                        c.reg_write   = 1'b1;
                    end
                    BR_B: c.branch = 1'b1;
                    BR_COND: begin
                        case (ir[10:8])
                            CC_BE:   c.branch = z;
                            CC_BLT:  c.branch = s ^ v;
                            CC_BLE:  c.branch = z | (s ^ v);
                            CC_BNE:  c.branch = ~z;
                            default: c.branch = 1'b0;
                        endcase
                    end
                    default: ;
                endcase
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Sequencer <-> datapath bundle: IR/flags in, phase and control strobes out.
interface phase_sequencer_if;
    import simple_pkg::*;

    logic [15:0]       ir;
    logic [3:0]        szcv;
    logic [PHASES-1:0] p;
    logic              running;
    logic              halted;
    logic              ir_load;
    logic              ab_load;
    logic              dr_load;
    logic              flag_we;
    logic              mem_read;
    logic              mem_write;
    logic              out_en;
    logic              reg_write;
    logic              mem_to_reg;
    logic              alu_src_imm;
    logic              pc_load_branch;
    logic              pc_inc;

    modport master (
        input  ir, szcv,
        output p, running, halted, ir_load, ab_load, dr_load, flag_we,
               mem_read, mem_write, out_en, reg_write, mem_to_reg,
               alu_src_imm, pc_load_branch, pc_inc
    );

    modport slave (
        output ir, szcv,
        input  p, running, halted, ir_load, ab_load, dr_load, flag_we,
               mem_read, mem_write, out_en, reg_write, mem_to_reg,
               alu_src_imm, pc_load_branch, pc_inc
    );
endinterface

// File: rtl/exec_sync.sv
// Multi-flop synchroniser for the asynchronous exec button plus a
// rising-edge detector producing a one-clock press pulse.
module exec_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic exec,
    output logic press
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], exec};
            level_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign press = sync_q[SYNC_STAGES-1] & ~level_q;
endmodule

// File: rtl/phase_sequencer.sv
// Run/stop controller and five-phase sequencer with registered control strobes.
// Build option SIMPLE_SINGLE_STEP_EN: each press runs exactly one instruction.
//
// state        | meaning
// ST_IDLE      | stopped, p=0 (single-step build: also stepping one instruction)
// ST_RUN       | free-running, p rotates p1..p5
// ST_STOP_PEND | stop requested, finishing current instruction
// ST_HALT      | HLT executed, only rst_n leaves
module phase_sequencer
    import simple_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              exec,
    phase_sequencer_if.master bus
);
    logic              press;
    seq_state_e        state_q, state_nx;
    logic [PHASES-1:0] p_q, p_nx;
    strobe_t           strb_q, strb_d;
    logic              running_q, running_d;
    logic              halted_q, halted_d;
    ctrl_t             dec;
    logic              at_wb;

    exec_sync #(.SYNC_STAGES(SYNC_STAGES)) u_exec_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .exec  (exec),
        .press (press)
    );

    assign dec   = decode(bus.ir, bus.szcv);
    assign at_wb = p_q[PH_WB];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            p_q       <= '0;
            strb_q    <= '0;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_nx;
            p_q       <= p_nx;
            strb_q    <= strb_d;
            running_q <= running_d;
            halted_q  <= halted_d;
        end
    end

    always_comb begin
        state_nx = state_q;
        p_nx     = '0;
`ifdef SIMPLE_SINGLE_STEP_EN
        case (state_q)
            ST_HALT: state_nx = ST_HALT;
            default: state_nx = (at_wb && dec.halt) ? ST_HALT : ST_IDLE;
        endcase
        if (state_nx == ST_IDLE) begin
            if (p_q == '0) begin
                if (press) p_nx = PH_FIRST;
            end else if (!at_wb) begin
                p_nx = rotate_phase(p_q);
            end
        end
`else
        case (state_q)
            ST_IDLE: if (press) state_nx = ST_RUN;
            ST_RUN: begin
                if (at_wb && dec.halt)
                    state_nx = ST_HALT;
                else if (press)
                    state_nx = at_wb ? ST_IDLE : ST_STOP_PEND;
            end
            ST_STOP_PEND: if (at_wb) state_nx = dec.halt ? ST_HALT : ST_IDLE;
            default: state_nx = ST_HALT;
        endcase
        if (state_nx == ST_RUN || state_nx == ST_STOP_PEND)
            p_nx = (p_q == '0) ? PH_FIRST : rotate_phase(p_q);
`endif
    end

    // SZCV is written at the end of p3, so the value seen while entering p5
    // already equals what the datapath holds during p5.
    always_comb begin
        strb_d                = '0;
        strb_d.ir_load        = p_nx[PH_FETCH];
        strb_d.ab_load        = p_nx[PH_REG];
        strb_d.dr_load        = p_nx[PH_EXEC];
        strb_d.flag_we        = p_nx[PH_EXEC] & dec.flag_we;
        strb_d.alu_src_imm    = p_nx[PH_EXEC] & dec.alu_src_imm;
        strb_d.mem_read       = p_nx[PH_MEM] & dec.mem_read;
        strb_d.mem_write      = p_nx[PH_MEM] & dec.mem_write;
        strb_d.out_en         = p_nx[PH_MEM] & dec.out_en;
        strb_d.reg_write      = p_nx[PH_WB] & dec.reg_write;
        strb_d.mem_to_reg     = p_nx[PH_WB] & dec.mem_to_reg;
        strb_d.pc_load_branch = p_nx[PH_WB] & dec.branch;
        strb_d.pc_inc         = p_nx[PH_WB] & ~dec.branch & ~dec.halt;
        running_d             = |p_nx;
        halted_d              = (state_nx == ST_HALT);
    end

    assign bus.p              = p_q;
    assign bus.running        = running_q;
    assign bus.halted         = halted_q;
    assign bus.ir_load        = strb_q.ir_load;
    assign bus.ab_load        = strb_q.ab_load;
    assign bus.dr_load        = strb_q.dr_load;
    assign bus.flag_we        = strb_q.flag_we;
    assign bus.mem_read       = strb_q.mem_read;
    assign bus.mem_write      = strb_q.mem_write;
    assign bus.out_en         = strb_q.out_en;
    assign bus.reg_write      = strb_q.reg_write;
    assign bus.mem_to_reg     = strb_q.mem_to_reg;
    assign bus.alu_src_imm    = strb_q.alu_src_imm;
    assign bus.pc_load_branch = strb_q.pc_load_branch;
    assign bus.pc_inc         = strb_q.pc_inc;
endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: per-instruction strobe table plus
// start latency, stop request, HLT and mid-phase reset sequences.
module tb_phase_sequencer;

    // flags = {flag_we, reg_write, mem_read, mem_write, out_en, mem_to_reg,
    //          alu_src_imm, branch_taken, pc_inc}
    typedef struct packed {
        logic [15:0] ir;
        logic [3:0]  szcv;
        logic [8:0]  flags;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic exec  = 1'b0;

    phase_sequencer_if bus ();

    phase_sequencer #(.SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .exec  (exec),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[$];

    logic [18:0] obs;
    assign obs = {bus.p, bus.running, bus.halted, bus.ir_load, bus.ab_load,
                  bus.dr_load, bus.flag_we, bus.mem_read, bus.mem_write,
                  bus.out_en, bus.reg_write, bus.mem_to_reg, bus.alu_src_imm,
                  bus.pc_load_branch, bus.pc_inc};

    task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic logic [18:0] exp_obs(input int ph, input vec_t v, input logic halted);
        logic [11:0] s;
        logic [4:0]  p;
        logic [8:0]  f;
        s = '0;
        p = '0;
        f = v.flags;
        if (ph >= 1) p = 5'b00001 << (ph - 1);
        case (ph)
            1: s[11] = 1'b1;
            2: s[10] = 1'b1;
            3: begin s[9] = 1'b1; s[8] = f[8]; s[2] = f[2]; end
            4: begin s[7] = f[6]; s[6] = f[5]; s[5] = f[4]; end
            5: begin s[4] = f[7]; s[3] = f[3]; s[1] = f[1]; s[0] = f[0]; end
            default: ;
        endcase
        return {p, (ph != 0), halted, s};
    endfunction

    task automatic wait_phase(input logic [4:0] ph, input string name);
        if (bus.p == ph) return;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.p == ph) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL %s: timeout waiting for p=%b, got p=%b", name, ph, bus.p);
    endtask

    task automatic pulse_exec();
        exec = 1'b1;
        repeat (2) @(negedge clk);
        exec = 1'b0;
    endtask

    // entered at the negedge inside p1 of the instruction
    task automatic run_vec(input vec_t v, input string name);
        check($sformatf("%s p1", name), obs, exp_obs(1, v, 1'b0));
        bus.ir   = v.ir;
        bus.szcv = v.szcv;
        for (int ph = 2; ph <= 5; ph++) begin
            @(negedge clk);
            check($sformatf("%s p%0d", name, ph), obs, exp_obs(ph, v, 1'b0));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t hlt_v;
        vec_t add_v;
        int   cnt;

        vecs.push_back({16'hC000, 4'h0, 9'b110000001}); // ADD
        vecs.push_back({16'hC010, 4'h0, 9'b110000001}); // SUB
        vecs.push_back({16'hC040, 4'h0, 9'b110000001}); // XOR
        vecs.push_back({16'hC050, 4'h0, 9'b100000001}); // CMP
        vecs.push_back({16'hC060, 4'h0, 9'b010000001}); // MOV
        vecs.push_back({16'hC070, 4'h0, 9'b000000001}); // unused op3
        vecs.push_back({16'hC0B0, 4'h0, 9'b110000001}); // SRA
        vecs.push_back({16'hC0C0, 4'h0, 9'b011001001}); // IN
        vecs.push_back({16'hC0D0, 4'h0, 9'b000010001}); // OUT
        vecs.push_back({16'hC0E0, 4'h0, 9'b000000001}); // unused op3
        vecs.push_back({16'h0A05, 4'h0, 9'b011001101}); // LD
        vecs.push_back({16'h4A05, 4'h0, 9'b000100101}); // ST
        vecs.push_back({16'h8105, 4'h0, 9'b010000101}); // LI
        vecs.push_back({16'hA005, 4'h0, 9'b000000010}); // B
        vecs.push_back({16'h8805, 4'h0, 9'b000000001}); // ir[13:11]=001 NOP
        vecs.push_back({16'hBB05, 4'h4, 9'b000000001}); // BNE, Z=1
        vecs.push_back({16'hBB05, 4'h0, 9'b000000010}); // BNE, Z=0
        vecs.push_back({16'hB805, 4'h4, 9'b000000010}); // BE, Z=1
        vecs.push_back({16'hB805, 4'h0, 9'b000000001}); // BE, Z=0
        vecs.push_back({16'hB905, 4'h8, 9'b000000010}); // BLT, S=1 V=0
        vecs.push_back({16'hB905, 4'h9, 9'b000000001}); // BLT, S=1 V=1
        vecs.push_back({16'hBA05, 4'h1, 9'b000000010}); // BLE, S^V=1
        vecs.push_back({16'hBA05, 4'h0, 9'b000000001}); // BLE, all clear
        vecs.push_back({16'hBC05, 4'h4, 9'b000000001}); // cond 100 never taken
        vecs.push_back({16'hBF05, 4'h0, 9'b000000001}); // cond 111 never taken
        hlt_v = {16'hC0F0, 4'h0, 9'b000000000};
        add_v = {16'hC000, 4'h0, 9'b110000001};

        bus.ir   = 16'hC070;
        bus.szcv = 4'h0;
        repeat (2) @(negedge clk);
        check("reset outputs", obs, 19'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // press latency: SYNC_STAGES+1 clocks to p1, then rotation
        exec = 1'b1;
        @(negedge clk);
        check("start lat 1", 19'(bus.p), 19'd0);
        @(negedge clk);
        check("start lat 2", 19'(bus.p), 19'd0);
        @(negedge clk);
        check("start p1", 19'(bus.p), 19'(5'b00001));
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("rotate p%0d", k + 1), 19'(bus.p), 19'(5'b00001 << k));
        end
        exec = 1'b0;
        @(negedge clk);
`ifdef SIMPLE_SINGLE_STEP_EN
        check("step ends idle", 19'(bus.p), 19'd0);
`else
        check("rotate wrap", 19'(bus.p), 19'(5'b00001));
`endif

        for (int i = 0; i < vecs.size(); i++) begin
`ifdef SIMPLE_SINGLE_STEP_EN
            pulse_exec();
`endif
            wait_phase(5'b00001, $sformatf("vec%0d start", i));
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

`ifdef SIMPLE_SINGLE_STEP_EN
        repeat (3) @(negedge clk);
        bus.ir = 16'hC000;
        pulse_exec();
        wait_phase(5'b00001, "step start");
        cnt = 1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.p != 5'b00000) cnt++;
        end
        check("step phase count", 19'(cnt), 19'd5);
`else
        // stop request during p2: instruction finishes, then idle
        wait_phase(5'b00010, "stop wait p2");
        exec = 1'b1;
        @(negedge clk);
        check("stop p3", 19'({bus.p, bus.running}), 19'({5'b00100, 1'b1}));
        @(negedge clk);
        check("stop p4", 19'({bus.p, bus.running}), 19'({5'b01000, 1'b1}));
        @(negedge clk);
        check("stop p5", 19'({bus.p, bus.running}), 19'({5'b10000, 1'b1}));
        @(negedge clk);
        check("stopped", obs, 19'd0);
        repeat (4) @(negedge clk);
        check("stays stopped", obs, 19'd0);
        exec = 1'b0;
`endif

        // HLT: sticky until reset, presses ignored
        repeat (4) @(negedge clk);
        bus.ir   = hlt_v.ir;
        bus.szcv = 4'h0;
        pulse_exec();
        wait_phase(5'b00001, "hlt start");
        run_vec(hlt_v, "hlt");
        @(negedge clk);
        check("halted", obs, exp_obs(0, hlt_v, 1'b1));
        pulse_exec();
        repeat (6) @(negedge clk);
        check("halt ignores press", obs, exp_obs(0, hlt_v, 1'b1));

        rst_n = 1'b0;
        @(negedge clk);
        check("reset clears halt", obs, 19'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // reset asserted mid-instruction
        bus.ir = add_v.ir;
        pulse_exec();
        wait_phase(5'b00100, "rst wait p3");
        check("pre-reset p3", obs, exp_obs(3, add_v, 1'b0));
        rst_n = 1'b0;
        #1;
        check("async reset p3", obs, 19'd0);
        @(negedge clk);
        check("reset held", obs, 19'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle after reset", obs, 19'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
